// File: rtl/rx_cmd_decoder_pkg.sv
// Shared constants for the receive-side command decoder: opcode values,
// FSM state encoding and the fixed register-file slots for ALU operands.
package rx_cmd_decoder_pkg;

  localparam logic [7:0] OPC_WRITE   = 8'hAA;  // write: addr, data
  localparam logic [7:0] OPC_READ    = 8'hBB;  // read: addr
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;  // ALU with operands: opA, opB, fun
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;  // ALU without operands: fun

  // Register-file slots the ALU reads its operands from
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_ALU_OPA = 3'd4,
    ST_ALU_OPB = 3'd5,
    ST_ALU_FUN = 3'd6
  } state_t;

endpackage

// File: rtl/rx_cmd_decoder.sv
// Byte-stream command decoder. Each valid received byte advances a frame
// FSM; completed frames become single-cycle register-file / ALU strobes.
// All outputs come straight from registers, one cycle after the byte.
module rx_cmd_decoder
  import rx_cmd_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] OPC_W  = DATA_WIDTH'(OPC_WRITE);
  localparam logic [DATA_WIDTH-1:0] OPC_R  = DATA_WIDTH'(OPC_READ);
  localparam logic [DATA_WIDTH-1:0] OPC_AO = DATA_WIDTH'(OPC_ALU_OP);
  localparam logic [DATA_WIDTH-1:0] OPC_AN = DATA_WIDTH'(OPC_ALU_NOP);
  localparam logic [ADDR_WIDTH-1:0] ADDR_A = ADDR_WIDTH'(OPA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B = ADDR_WIDTH'(OPB_ADDR);

  state_t                  state_reg, state_next;
  logic                    wr_en_reg, wr_en_next;
  logic                    rd_en_reg, rd_en_next;
  logic                    alu_en_reg, alu_en_next;
  logic                    cmd_err_reg, cmd_err_next;
  logic                    gate_reg, gate_next;
  logic                    alu_en_d_reg;
  logic [ADDR_WIDTH-1:0]   address_reg, address_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic [3:0]              alu_fun_reg, alu_fun_next;

  // State and output registers; reset drops any partial frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= ST_IDLE;
      wr_en_reg    <= 1'b0;
      rd_en_reg    <= 1'b0;
      alu_en_reg   <= 1'b0;
      cmd_err_reg  <= 1'b0;
      gate_reg     <= 1'b0;
      alu_en_d_reg <= 1'b0;
      address_reg  <= '0;
      wr_data_reg  <= '0;
      alu_fun_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wr_en_reg    <= wr_en_next;
      rd_en_reg    <= rd_en_next;
      alu_en_reg   <= alu_en_next;
      cmd_err_reg  <= cmd_err_next;
      gate_reg     <= gate_next;
      alu_en_d_reg <= alu_en_reg;
      address_reg  <= address_next;
      wr_data_reg  <= wr_data_next;
      alu_fun_reg  <= alu_fun_next;
    end
  end

  // Next-state and next-output decode for the byte presented this cycle
  always_comb begin
    state_next   = state_reg;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    alu_en_next  = 1'b0;
    cmd_err_next = 1'b0;
    address_next = address_reg;
    wr_data_next = wr_data_reg;
    alu_fun_next = alu_fun_reg;
    gate_next    = gate_reg;

    // The gate is released the cycle after ALU_EN drops, unless a new
    // ALU frame has already started (FSM no longer idle) in the meantime.
    if (alu_en_d_reg && (state_reg == ST_IDLE)) begin
      gate_next = 1'b0;
    end

    if (RX_D_VLD) begin
      case (state_reg)
        ST_IDLE: begin
          if (RX_P_DATA == OPC_W) begin
            state_next = ST_WR_ADDR;
          end else if (RX_P_DATA == OPC_R) begin
            state_next = ST_RD_ADDR;
          end else if (RX_P_DATA == OPC_AO) begin
            state_next = ST_ALU_OPA;
            gate_next  = 1'b1;
          end else if (RX_P_DATA == OPC_AN) begin
            state_next = ST_ALU_FUN;
            gate_next  = 1'b1;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
        ST_WR_ADDR: begin
          address_next = RX_P_DATA[ADDR_WIDTH-1:0];
          state_next   = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          wr_data_next = RX_P_DATA;
          wr_en_next   = 1'b1;
          state_next   = ST_IDLE;
        end
        ST_RD_ADDR: begin
          address_next = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_next   = 1'b1;
          state_next   = ST_IDLE;
        end
        ST_ALU_OPA: begin
          address_next = ADDR_A;
          wr_data_next = RX_P_DATA;
          wr_en_next   = 1'b1;
          state_next   = ST_ALU_OPB;
        end
        ST_ALU_OPB: begin
          address_next = ADDR_B;
          wr_data_next = RX_P_DATA;
          wr_en_next   = 1'b1;
          state_next   = ST_ALU_FUN;
        end
        ST_ALU_FUN: begin
          alu_fun_next = RX_P_DATA[3:0];
          alu_en_next  = 1'b1;
          state_next   = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign WrEn        = wr_en_reg;
  assign RdEn        = rd_en_reg;
  assign ALU_EN      = alu_en_reg;
  assign CMD_ERR     = cmd_err_reg;
  assign CLK_GATE_EN = gate_reg;
  assign Address     = address_reg;
  assign WrData      = wr_data_reg;
  assign ALU_FUN     = alu_fun_reg;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Table-driven bench for rx_cmd_decoder: one record per clock cycle gives
// the byte presented and the outputs expected right after that edge.
module tb_rx_cmd_decoder;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_ERR;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [3:0] ALU_FUN;

  int total = 0;
  int bad   = 0;

  rx_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .CMD_ERR(CMD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {WrEn, RdEn, ALU_EN, CMD_ERR, CLK_GATE_EN, Address, WrData, ALU_FUN}
  typedef logic [20:0] obs_t;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    obs_t       exp;
  } vec_t;

  vec_t vq[$];

  function automatic obs_t pk(input logic wr, input logic rd, input logic alu,
                              input logic err, input logic gate,
                              input logic [3:0] a, input logic [7:0] d,
                              input logic [3:0] f);
    return {wr, rd, alu, err, gate, a, d, f};
  endfunction

  function automatic obs_t observed();
    return {WrEn, RdEn, ALU_EN, CMD_ERR, CLK_GATE_EN, Address, WrData, ALU_FUN};
  endfunction

  task automatic add(input logic vld, input logic [7:0] data, input obs_t exp);
    vec_t v;
    v.vld  = vld;
    v.data = data;
    v.exp  = exp;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = observed();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end else begin
      $display("ok   %s out=%h", name, got);
    end
  endtask

  // Present one byte (or an idle cycle) for one clock and check the result
  task automatic step(input string name, input logic vld, input logic [7:0] data,
                      input obs_t exp);
    @(negedge CLK);
    RX_D_VLD  = vld;
    RX_P_DATA = data;
    @(posedge CLK);
    #1;
    check(name, exp);
  endtask

  initial begin
    RST       = 1'b0;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'h00;

    // Write frame with idle gaps: AA, 05, 3C
    add(1, 8'hAA, pk(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
    add(1, 8'h05, pk(0,0,0,0,0, 4'h5, 8'h00, 4'h0));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h5, 8'h00, 4'h0));
    add(1, 8'h3C, pk(1,0,0,0,0, 4'h5, 8'h3C, 4'h0));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h5, 8'h3C, 4'h0));
    // Read frame BB, 1F: upper address bits ignored
    add(1, 8'hBB, pk(0,0,0,0,0, 4'h5, 8'h3C, 4'h0));
    add(1, 8'h1F, pk(0,1,0,0,0, 4'hF, 8'h3C, 4'h0));
    add(0, 8'h00, pk(0,0,0,0,0, 4'hF, 8'h3C, 4'h0));
    // ALU frame back-to-back: CC, 12, 34, 07
    add(1, 8'hCC, pk(0,0,0,0,1, 4'hF, 8'h3C, 4'h0));
    add(1, 8'h12, pk(1,0,0,0,1, 4'h0, 8'h12, 4'h0));
    add(1, 8'h34, pk(1,0,0,0,1, 4'h1, 8'h34, 4'h0));
    add(1, 8'h07, pk(0,0,1,0,1, 4'h1, 8'h34, 4'h7));
    add(0, 8'h00, pk(0,0,0,0,1, 4'h1, 8'h34, 4'h7));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h1, 8'h34, 4'h7));
    // Invalid opcode 55, then DD, 02
    add(1, 8'h55, pk(0,0,0,1,0, 4'h1, 8'h34, 4'h7));
    add(1, 8'hDD, pk(0,0,0,0,1, 4'h1, 8'h34, 4'h7));
    add(1, 8'h02, pk(0,0,1,0,1, 4'h1, 8'h34, 4'h2));
    add(0, 8'h00, pk(0,0,0,0,1, 4'h1, 8'h34, 4'h2));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h1, 8'h34, 4'h2));
    // Opcode value as payload: AA, 0A, AA; then BB, 03 proves FSM is idle
    add(1, 8'hAA, pk(0,0,0,0,0, 4'h1, 8'h34, 4'h2));
    add(1, 8'h0A, pk(0,0,0,0,0, 4'hA, 8'h34, 4'h2));
    add(1, 8'hAA, pk(1,0,0,0,0, 4'hA, 8'hAA, 4'h2));
    add(1, 8'hBB, pk(0,0,0,0,0, 4'hA, 8'hAA, 4'h2));
    add(1, 8'h03, pk(0,1,0,0,0, 4'h3, 8'hAA, 4'h2));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h3, 8'hAA, 4'h2));
    // Another invalid opcode (00)
    add(1, 8'h00, pk(0,0,0,1,0, 4'h3, 8'hAA, 4'h2));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h3, 8'hAA, 4'h2));
    // DD, F9 (upper function bits ignored), then CC right after: gate held
    add(1, 8'hDD, pk(0,0,0,0,1, 4'h3, 8'hAA, 4'h2));
    add(1, 8'hF9, pk(0,0,1,0,1, 4'h3, 8'hAA, 4'h9));
    add(1, 8'hCC, pk(0,0,0,0,1, 4'h3, 8'hAA, 4'h9));
    add(0, 8'h00, pk(0,0,0,0,1, 4'h3, 8'hAA, 4'h9));
    add(0, 8'h00, pk(0,0,0,0,1, 4'h3, 8'hAA, 4'h9));
    add(1, 8'h11, pk(1,0,0,0,1, 4'h0, 8'h11, 4'h9));
    add(1, 8'h22, pk(1,0,0,0,1, 4'h1, 8'h22, 4'h9));
    add(1, 8'h03, pk(0,0,1,0,1, 4'h1, 8'h22, 4'h3));
    add(0, 8'h00, pk(0,0,0,0,1, 4'h1, 8'h22, 4'h3));
    add(0, 8'h00, pk(0,0,0,0,0, 4'h1, 8'h22, 4'h3));

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset", pk(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("vec%0d_%s_%h", i, vq[i].vld ? "vld" : "idle", vq[i].data),
           vq[i].vld, vq[i].data, vq[i].exp);
    end

    // Reset in the middle of a write frame: AA, 03, reset, then BB, 04
    step("mid_aa", 1, 8'hAA, pk(0,0,0,0,0, 4'h1, 8'h22, 4'h3));
    step("mid_03", 1, 8'h03, pk(0,0,0,0,0, 4'h3, 8'h22, 4'h3));
    @(negedge CLK);
    RX_D_VLD  = 1'b1;
    RX_P_DATA = 8'h3C;
    #2;
    RST = 1'b0;
    #1;
    check("rst_async", pk(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
    @(posedge CLK);
    #1;
    check("rst_held", pk(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
    @(negedge CLK);
    RST      = 1'b1;
    RX_D_VLD = 1'b0;
    step("post_bb", 1, 8'hBB, pk(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
    step("post_04", 1, 8'h04, pk(0,1,0,0,0, 4'h4, 8'h00, 4'h0));
    step("post_idle", 0, 8'h00, pk(0,0,0,0,0, 4'h4, 8'h00, 4'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
